// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encoding and default operand width for serial_subtractor.
package serial_sub_pkg;
    localparam int DEF_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational subtractor cell computing a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b over WIDTH cycles through one full_subtractor cell.
// Optional macro SERIAL_SUB_OVF_EN adds the two's-complement overflow flag and its MSB-capture registers.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [CW-1:0]    cnt;
    logic             borrow, d, bout, load, last;

    full_subtractor u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .bin (borrow),
        .d   (d),
        .bout(bout)
    );

    // start is only honoured outside SHIFT, so a mid-transaction request is dropped
    assign load = start_i && state != SHIFT;
    assign last = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) state <= IDLE;
        else          state <= next_state;

    always_comb begin
        next_state = (state == SHIFT) ? (last ? DONE : SHIFT) : (start_i ? SHIFT : IDLE);
    end

    always_comb begin
        busy_o = state == SHIFT;
        done_o = state == DONE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
        end else if (load) begin
            a_sh   <= a_i;
            b_sh   <= b_i;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res    <= {d, res[WIDTH-1:1]};
            borrow <= bout;
            cnt    <= cnt + 1'b1;
            if (last) begin
                diff_o   <= {d, res[WIDTH-1:1]};
                borrow_o <= bout;
            end
        end

`ifdef SERIAL_SUB_OVF_EN
    // operand sign bits are shifted away, so keep them for the final overflow test
    logic a_msb, b_msb, ovf_q;

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (load) begin
            a_msb <= a_i[WIDTH-1];
            b_msb <= b_i[WIDTH-1];
        end else if (state == SHIFT && last) begin
            ovf_q <= (a_msb != b_msb) & (d != a_msb);
        end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors with a result scoreboard checked on every done_o pulse.
module tb_serial_subtractor;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, borrow, ovf;
    logic [7:0] diff;
    exp_t       q[$];
    int         checks = 0, errors = 0;
    int         lat, bz;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .diff_o  (diff),
        .borrow_o(borrow),
        .ovf_o   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                         input logic eb, input logic eo, input bit push);
        a = av;
        b = bv;
        start = 1'b1;
        if (push) q.push_back('{d: ed, b: eb, o: eo});
    endtask

    task automatic wait_done(output int l, output int bn);
        l = 0;
        bn = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) bn++;
            if (done) begin
                l = n;
                break;
            end
        end
        if (l == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    task automatic run(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                       input logic eb, input logic eo);
        issue(av, bv, ed, eb, eo, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bz);
        chk("latency", lat, 9);
        chk("busy_cycles", bz, 8);
    endtask

    always @(negedge clk)
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done expected none (diff %0h)", diff);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", diff, e.d);
                chk("borrow", borrow, e.b);
                chk("ovf", ovf, e.o);
            end
        end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_diff", diff, 8'h02);
        chk("idle_done", done, 0);
        run(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run(8'h80, 8'h01, 8'h7F, 1'b0, OVF_EN);
        run(8'h7F, 8'hFF, 8'h80, 1'b1, OVF_EN);
        run(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        // start pulse during SHIFT must be ignored
        issue(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        issue(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bz);
        chk("ignored_start_latency", lat, 5);
        // async reset in the middle of SHIFT
        @(negedge clk);
        issue(8'h55, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow, 0);
        chk("abort_ovf", ovf, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        // back-to-back start held in DONE
        issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bz);
        issue(8'h20, 8'h01, 8'h1F, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_hold_diff", diff, 8'h02);
        wait_done(lat, bz);
        chk("b2b_latency", lat, 9);
        repeat (12) @(negedge clk);
        chk("pending", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
